// File: rtl/mostra_sequencia_if.sv
// Signal bundle between the sequence presenter, the sequence ROM and the board LEDs.
// The master side drives the start request, limit and ROM data; the slave is the presenter.
interface mostra_sequencia_if;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] mem_dado;
  logic [3:0] mem_endereco;
  logic [3:0] leds;
  logic       mostrando;
  logic       pronto;
  logic [3:0] db_estado;

  modport master (
    output iniciar, limite, mem_dado,
    input  mem_endereco, leds, mostrando, pronto, db_estado
  );

  modport slave (
    input  iniciar, limite, mem_dado,
    output mem_endereco, leds, mostrando, pronto, db_estado
  );
endinterface

// File: rtl/mostra_sequencia.sv
// Sequence presenter: shows ROM positions 0..limite on the LEDs, each lit for ON_CYCLES
// then dark for OFF_CYCLES, and pulses pronto when the whole sequence has been shown.
module mostra_sequencia #(
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500
) (
  input  logic                clock,
  input  logic                reset,
  mostra_sequencia_if.slave   bus
);

  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    PREPARA = 4'h1,
    LEITURA = 4'h2,
    ACESO   = 4'h3,
    APAGADO = 4'h4,
    PROXIMO = 4'h5,
    FIM     = 4'hF
  } estado_t;

  estado_t       state_q, state_d;
  logic [3:0]    pos_q, pos_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    dado_q, dado_d;
  logic [3:0]    limite_q, limite_d;
  logic [3:0]    leds_q;
  logic          mostrando_q;
  logic          pronto_q;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    timer_d  = timer_q;
    dado_d   = dado_q;
    limite_d = limite_q;
    unique case (state_q)
      INICIAL: if (bus.iniciar) state_d = PREPARA;
      PREPARA: begin
        pos_d    = '0;
        timer_d  = '0;
        limite_d = bus.limite;
        state_d  = LEITURA;
      end
      LEITURA: begin
        dado_d  = bus.mem_dado;
        timer_d = '0;
        state_d = ACESO;
      end
      ACESO: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = APAGADO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      APAGADO: begin
        // Cleared on exit rather than incremented, so the timer never wraps.
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          state_d = (pos_q == limite_q) ? FIM : PROXIMO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PROXIMO: begin
        pos_d   = pos_q + 4'd1;
        state_d = LEITURA;
      end
      FIM:     state_d = INICIAL;
      default: state_d = INICIAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= INICIAL;
      pos_q       <= '0;
      timer_q     <= '0;
      dado_q      <= '0;
      limite_q    <= '0;
      leds_q      <= '0;
      mostrando_q <= 1'b0;
      pronto_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      timer_q     <= timer_d;
      dado_q      <= dado_d;
      limite_q    <= limite_d;
      // Outputs are decoded from the next state so they switch on the same edge as the state.
      leds_q      <= (state_d == ACESO) ? dado_d : 4'd0;
      mostrando_q <= (state_d == PREPARA) || (state_d == LEITURA) || (state_d == ACESO) ||
                     (state_d == APAGADO) || (state_d == PROXIMO);
      pronto_q    <= (state_d == FIM);
    end
  end

  assign bus.leds         = leds_q;
  assign bus.mostrando    = mostrando_q;
  assign bus.pronto       = pronto_q;
  assign bus.mem_endereco = pos_q;
  assign bus.db_estado    = state_q;

endmodule

// File: tb/tb_mostra_sequencia.sv
// Self-checking bench for mostra_sequencia with ON_CYCLES=3, OFF_CYCLES=2: table of
// whole-presentation timings, per-cycle comparison against a sequence model, and corner cases.
module tb_mostra_sequencia;

  localparam int ON  = 3;
  localparam int OFF = 2;

  logic clock;
  logic reset;
  logic [3:0] mem [16];

  int errors = 0;
  int checks = 0;

  mostra_sequencia_if bus ();

  assign bus.mem_dado = mem[bus.mem_endereco];

  mostra_sequencia #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] leds;
    logic       mostrando;
    logic       pronto;
    logic [3:0] estado;
    logic [3:0] addr;
    bit         addr_valid;
  } exp_t;

  typedef struct {
    logic [3:0] lim;
    logic [3:0] val;
    int         exp_fim_edge;
    int         exp_lit;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] l, input logic m, input logic p,
                              input logic [3:0] e, input logic [3:0] a, input bit v);
    exp_t x;
    x.leds = l; x.mostrando = m; x.pronto = p; x.estado = e; x.addr = a; x.addr_valid = v;
    return x;
  endfunction

  // Expected visible behaviour, cycle by cycle after the sampling edge, from the presentation rules.
  task automatic build_model(input int lim, input bit hold, output exp_t q[$]);
    q = {};
    q.push_back(mk(4'd0, 1'b1, 1'b0, 4'h1, 4'd0, 1'b0));
    for (int i = 0; i <= lim; i++) begin
      q.push_back(mk(4'd0, 1'b1, 1'b0, 4'h2, 4'(i), 1'b1));
      for (int c = 0; c < ON; c++)  q.push_back(mk(mem[i], 1'b1, 1'b0, 4'h3, 4'(i), 1'b1));
      for (int c = 0; c < OFF; c++) q.push_back(mk(4'd0,   1'b1, 1'b0, 4'h4, 4'(i), 1'b1));
      if (i < lim) q.push_back(mk(4'd0, 1'b1, 1'b0, 4'h5, 4'(i), 1'b1));
    end
    q.push_back(mk(4'd0, 1'b0, 1'b1, 4'hF, 4'(lim), 1'b1));
    q.push_back(mk(4'd0, 1'b0, 1'b0, 4'h0, 4'(lim), 1'b1));
    if (hold) q.push_back(mk(4'd0, 1'b1, 1'b0, 4'h1, 4'(lim), 1'b1));
  endtask

  // Starts a presentation from idle and compares every cycle with the model.
  task automatic run_show(input int lim, input bit disturb, input bit hold, input string tag);
    exp_t q[$];
    bit pulse_on = 0, pulsed = 0, lim_done = 0;
    build_model(lim, hold, q);
    bus.limite  = 4'(lim);
    bus.iniciar = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) bus.iniciar = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      check($sformatf("%s leds@%0d", tag, k), 32'(bus.leds), 32'(q[k].leds));
      check($sformatf("%s mostrando@%0d", tag, k), 32'(bus.mostrando), 32'(q[k].mostrando));
      check($sformatf("%s pronto@%0d", tag, k), 32'(bus.pronto), 32'(q[k].pronto));
      check($sformatf("%s estado@%0d", tag, k), 32'(bus.db_estado), 32'(q[k].estado));
      if (q[k].addr_valid)
        check($sformatf("%s addr@%0d", tag, k), 32'(bus.mem_endereco), 32'(q[k].addr));
      if (disturb) begin
        if (pulse_on) begin
          bus.iniciar = 1'b0;
          pulse_on = 0;
        end
        if (q[k].estado == 4'h3 && !pulsed) begin
          bus.iniciar = 1'b1;
          pulse_on = 1;
          pulsed = 1;
        end
        if (q[k].estado == 4'h4 && !lim_done) begin
          bus.limite = 4'd0;
          lim_done = 1;
        end
      end
    end
    bus.iniciar = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    vec_t vecs[5];
    int   fim_edge, lit, prontos, edges;
    bit   found;

    // Reset held from time 0 with a start request present.
    reset       = 1'b0;
    bus.iniciar = 1'b1;
    bus.limite  = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("rst leds", 32'(bus.leds), 32'd0);
      check("rst mostrando", 32'(bus.mostrando), 32'd0);
      check("rst pronto", 32'(bus.pronto), 32'd0);
      check("rst estado", 32'(bus.db_estado), 32'd0);
      check("rst addr", 32'(bus.mem_endereco), 32'd0);
    end
    bus.iniciar = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle after reset", 32'(bus.db_estado), 32'd0);

    // Whole-presentation timing table: FIM edge count, lit cycles, single pronto.
    vecs[0] = '{lim: 4'd0,  val: 4'hA, exp_fim_edge: 7,   exp_lit: 3};
    vecs[1] = '{lim: 4'd3,  val: 4'h5, exp_fim_edge: 28,  exp_lit: 12};
    vecs[2] = '{lim: 4'd7,  val: 4'h1, exp_fim_edge: 56,  exp_lit: 24};
    vecs[3] = '{lim: 4'd15, val: 4'hF, exp_fim_edge: 112, exp_lit: 48};
    vecs[4] = '{lim: 4'd2,  val: 4'h0, exp_fim_edge: 21,  exp_lit: 0};
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 16; i++) mem[i] = vecs[v].val;
      @(posedge clock);
      #1;
      bus.limite  = vecs[v].lim;
      bus.iniciar = 1'b1;
      @(posedge clock);
      #1;
      bus.iniciar = 1'b0;
      edges = 0; lit = 0; prontos = 0; fim_edge = -1;
      while (edges < 200 && !(fim_edge >= 0 && edges >= fim_edge + 3)) begin
        @(posedge clock);
        #1;
        edges++;
        if (bus.leds != 4'd0) lit++;
        if (bus.pronto) begin
          prontos++;
          if (fim_edge < 0) fim_edge = edges;
        end
      end
      check($sformatf("vec%0d fim_edge", v), 32'(fim_edge), 32'(vecs[v].exp_fim_edge));
      check($sformatf("vec%0d lit_cycles", v), 32'(lit), 32'(vecs[v].exp_lit));
      check($sformatf("vec%0d pronto_count", v), 32'(prontos), 32'd1);
    end

    // Single value, then one-hot walk, then the same walk with start/limit disturbances.
    mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
    run_show(0, 1'b0, 1'b0, "lim0");
    run_show(3, 1'b0, 1'b0, "onehot");
    run_show(3, 1'b1, 1'b0, "disturb");

    // Reset asserted while 0100 is lit must clear outputs before the next edge.
    @(posedge clock);
    #1;
    bus.limite  = 4'd3;
    bus.iniciar = 1'b1;
    @(posedge clock);
    #1;
    bus.iniciar = 1'b0;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(posedge clock);
      #1;
      if (bus.leds == 4'b0100) found = 1;
    end
    check("reached 0100", 32'(found), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst leds", 32'(bus.leds), 32'd0);
    check("midrst mostrando", 32'(bus.mostrando), 32'd0);
    check("midrst estado", 32'(bus.db_estado), 32'd0);
    check("midrst addr", 32'(bus.mem_endereco), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("post-rst idle estado", 32'(bus.db_estado), 32'd0);
    check("post-rst idle mostrando", 32'(bus.mostrando), 32'd0);
    run_show(3, 1'b0, 1'b0, "restart");

    // Full-length sequence with iniciar held high through FIM.
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    run_show(15, 1'b0, 1'b1, "lim15");
    do_reset();

    // Random limits and memory contents against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
      run_show(int'($urandom_range(0, 7)), 1'b0, 1'b0, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mostra_sequencia.md
# mostra_sequencia

Sequence presenter for the memory game: on `iniciar`, reads positions 0..`limite` of the sequence memory and shows each value on `leds` for a fixed on-time followed by a fixed dark gap, then pulses `pronto`. It is the output half of the game interface. It drives the pattern the player must reproduce, while the existing control/datapath pair reads `chaves` and compares them against the same memory. The block sits between the sequence ROM and the board LEDs. Its 4-bit `db_estado` feeds a `hexa7seg` display.

## Interface
- `ON_CYCLES`, default 1000: clock cycles each value is lit; must be ≥1.
- `OFF_CYCLES`, default 500: clock cycles of dark gap after each value; must be ≥1.
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low. This is already decided.
- `iniciar` input 1: start request; sampled only in INICIAL.
- `limite` input 4: index of the last position to show (inclusive); captured in PREPARA.
- `mem_dado` input 4: memory read data; combinational function of `mem_endereco`.
- `mem_endereco` output 4: memory address, equal to the position counter.
- `leds` output 4: displayed value; 0 when not lit.
- `mostrando` output 1: high while a presentation is in progress.
- `pronto` output 1: one-cycle pulse when the presentation completes.
- `db_estado` output 4: current state code.

## Operation
- Internal registers:
  - state register
  - 4-bit position counter `pos`
  - timer, wide enough for max(ON_CYCLES, OFF_CYCLES)−1
  - 4-bit `dado_reg`
  - 4-bit `limite_reg`
- States, with code in hex:
  - INICIAL (0): idle. Goes to PREPARA when `iniciar`=1.
  - PREPARA (1): clears `pos` and the timer, and captures `limite` into `limite_reg`. Goes to LEITURA.
  - LEITURA (2): captures `mem_dado` into `dado_reg` and clears the timer. Goes to ACESO.
  - ACESO (3): timer increments. When timer = ON_CYCLES−1, clears the timer and goes to APAGADO.
  - APAGADO (4): timer increments. When timer = OFF_CYCLES−1, goes to FIM if `pos` = `limite_reg`, otherwise to PROXIMO.
  - PROXIMO (5): `pos` ← `pos`+1. Goes to LEITURA.
  - FIM (F): `pronto`=1. Goes to INICIAL unconditionally.
- Output decode (Moore, from state):
  - `leds` = `dado_reg` in ACESO, 0 in every other state.
  - `mostrando` = 1 in PREPARA, LEITURA, ACESO, APAGADO and PROXIMO.
  - `pronto` = 1 only in FIM.
  - `mem_endereco` = `pos`.
  - `db_estado` = state code.
- `mem_dado` is shown as-is with no one-hot check. A value of 0 produces a dark "lit" interval of the normal length.
- Boundary behaviour:
  - `iniciar` is ignored outside INICIAL.
  - `iniciar` held high through FIM starts a new presentation one cycle after returning to INICIAL.
  - `limite` changes after PREPARA have no effect on the running presentation.
  - `limite`=15 shows 16 values, and `pos` ends at 15 without wrapping.
  - `limite`=0 shows exactly one value.
  - The position counter and timer never wrap during legal operation.

## Timing
- Reset values (reset=0, asynchronous, no clock needed):
  - state = INICIAL
  - `pos`, timer, `dado_reg` and `limite_reg` = 0
  - outputs: `leds`=0, `mostrando`=0, `pronto`=0, `mem_endereco`=0, `db_estado`=0
- Reset asserted mid-presentation returns the block to these values immediately. After release the block is idle until the next `iniciar`.
- Per shown value:
  - 1 LEITURA cycle
  - ON_CYCLES lit
  - OFF_CYCLES dark
  - plus 1 PROXIMO cycle between values
- From the edge that samples `iniciar`=1 to the edge entering FIM, the count is 1 + (L+1)·(1+ON_CYCLES+OFF_CYCLES) + L edges, where L = `limite_reg`.
- `pronto` is high for exactly one cycle after that edge.
- `leds` changes exactly on the edges entering and leaving ACESO, with no glitches between values.
- `mem_dado` must be stable one cycle after `mem_endereco` changes, because it is sampled in LEITURA.

## Test plan
All scenarios use ON_CYCLES=3 and OFF_CYCLES=2.
- Reset low at time 0 with `iniciar`=1 → all outputs 0 and `db_estado`=0 for the whole reset; no state change until release.
- `limite`=0, mem[0]=0001, one-cycle `iniciar` pulse → `leds`=0001 for exactly 3 cycles, then 0 for 2 cycles. `pronto` pulses once, with FIM entered 7 edges after the sampling edge. `mostrando` falls as FIM is entered.
- `limite`=3, mem = 0001, 0010, 0100, 1000 → `mem_endereco` steps 0→3. `leds` shows 0001, 0010, 0100, 1000, each for 3 cycles with 2-cycle gaps. FIM is entered at edge 28 and `pronto` pulses once.
- `iniciar` re-pulsed during ACESO, and `limite` changed to 0 during APAGADO, with `limite`=3 at start → no restart, and all 4 values are still shown.
- Reset driven low while in ACESO showing 0100 → `leds`=0, `mostrando`=0, `db_estado`=0 before the next clock edge. After release, the block idles and a fresh `iniciar` restarts from address 0.
- `limite`=15, mem[i]=i → 16 values are shown and `mem_endereco` peaks at 15 with no wrap. `pronto` arrives at edge 1+16·6+15=112. `iniciar` held high afterward → a new presentation begins, with PREPARA entered 2 edges after FIM.
